vec2_sum_collector: RTL and testbench

//   Downstream consumer of the DPI-C vec2 add stage.
//   - Mirrors the add stage's en.
//   - Captures sum_vec the cycle after each issued beat.
//   - Per lane, accumulates ACC_LEN beats into one group result (saturating).
//   - Buffers group results in a DEPTH-entry FIFO with a valid/ready output.
//   - Returns issue_ready so the issuer never overruns the FIFO.

---
 rtl/vec2_sum_collector_if.sv | 43 ++++
 rtl/vec2_sum_collector.sv | 137 +++++++++++++
 tb/tb_vec2_sum_collector.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vec2_sum_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : vec2_sum_collector_if
// Brief    : Issue/capture and result handshake bundle for vec2_sum_collector.
//            The master side is the issuer plus result consumer.
//            The slave side is the collector.
// Revision : 1.0  initial release
// ============================================================================
interface vec2_sum_collector_if #(
  parameter int LANE_W = 8
);
  logic                  issue_en;
  logic [2*LANE_W-1:0]   sum_vec;
  logic                  issue_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*LANE_W-1:0]   out_vec;
  logic                  overflow;
  logic                  clr_overflow;

  modport master (
    output issue_en,
    output sum_vec,
    output out_ready,
    output clr_overflow,
    input  issue_ready,
    input  out_valid,
    input  out_vec,
    input  overflow
  );

  modport slave (
    input  issue_en,
    input  sum_vec,
    input  out_ready,
    input  clr_overflow,
    output issue_ready,
    output out_valid,
    output out_vec,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/vec2_sum_collector.sv
`default_nettype none
// ============================================================================
// Module   : vec2_sum_collector
// Brief    : Captures the vec2 add stage result one cycle after each issued
//            beat. Each lane accumulates ACC_LEN beats with saturation, and
//            each finished group is pushed into a DEPTH-entry valid/ready
//            FIFO. Issue credit is returned so that a well-behaved issuer
//            never overruns the FIFO.
// Revision : 1.0  initial release
// ============================================================================
module vec2_sum_collector #(
  parameter int LANE_W  = 8,
  parameter int ACC_LEN = 4,
  parameter int DEPTH   = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  vec2_sum_collector_if.slave bus
);

  localparam int c_VW = 2 * LANE_W;
  localparam int c_AW = $clog2(DEPTH);
  // A 1-bit counter is kept even for ACC_LEN=1; it then simply stays at 0.
  localparam int c_CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  localparam logic [c_CW-1:0] c_LAST   = c_CW'(ACC_LEN - 1);
  localparam logic [c_AW:0]   c_FULL   = (c_AW + 1)'(DEPTH);
  // Leave one free slot for the group that may already be in flight.
  localparam logic [c_AW:0]   c_CREDIT = (c_AW + 1)'(DEPTH - 2);

  logic                     r_cap_pending;
  logic [c_CW-1:0]          r_beat_cnt;
  logic [1:0][LANE_W-1:0]   r_acc;
  logic [1:0][LANE_W-1:0]   w_nxt;

  logic [c_VW-1:0]          r_mem [DEPTH];
  logic [c_AW-1:0]          r_wr_ptr;
  logic [c_AW-1:0]          r_rd_ptr;
  logic [c_AW:0]            r_count;
  logic                     r_overflow;

  logic                     w_capture;
  logic                     w_group_done;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;

  // Per-lane unsigned add with saturation at the all-ones value.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [LANE_W:0] w_sum;
    assign w_sum    = {1'b0, r_acc[l]} + {1'b0, bus.sum_vec[l*LANE_W +: LANE_W]};
    assign w_nxt[l] = w_sum[LANE_W] ? {LANE_W{1'b1}} : w_sum[LANE_W-1:0];
  end

  assign w_capture    = r_cap_pending;
  assign w_group_done = w_capture && (r_beat_cnt == c_LAST);
  assign w_full       = (r_count == c_FULL);
  assign w_pop        = (r_count != '0) && bus.out_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still
  // accept a push when it is also being drained.
  assign w_push       = w_group_done && (!w_full || w_pop);
  assign w_drop       = w_group_done && w_full && !w_pop;

  // The add stage result is valid the cycle after issue_en was sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_pending <= 1'b0;
    end else begin
      r_cap_pending <= bus.issue_en;
    end
  end

  // Beat counter and lane accumulators; both restart after every group,
  // whether the group was stored or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
    end else if (w_capture) begin
      if (w_group_done) begin
        r_beat_cnt <= '0;
        r_acc      <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        r_acc      <= w_nxt;
      end
    end
  end

  // FIFO storage; contents past the read pointer are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_nxt;
    end
  end

  // FIFO pointers and occupancy; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // All outputs come from registered state only, so out_ready cannot reach them.
  assign bus.out_valid   = (r_count != '0);
  assign bus.out_vec     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.issue_ready = (r_count <= c_CREDIT);
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vec2_sum_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec2_sum_collector
// Brief    : Directed self-checking bench for vec2_sum_collector. It runs an
//            ACC_LEN=4/DEPTH=4 instance and a second ACC_LEN=1 instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_vec2_sum_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec2_sum_collector_if #(.LANE_W(8)) bus  ();
  vec2_sum_collector_if #(.LANE_W(8)) bus1 ();

  vec2_sum_collector #(.LANE_W(8), .ACC_LEN(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec2_sum_collector #(.LANE_W(8), .ACC_LEN(1), .DEPTH(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [15:0] beat_val;
  logic [15:0] beat_val1;
  int n_tests = 0;
  int n_fail  = 0;

  // Stand-in for the add stage: registers the beat on the edge that samples en.
  always @(posedge clk) begin
    if (bus.issue_en)  bus.sum_vec  <= beat_val;
    if (bus1.issue_en) bus1.sum_vec <= beat_val1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One issued beat; the caller may chain these back to back.
  task automatic beat(input logic [15:0] v);
    beat_val     = v;
    bus.issue_en = 1'b1;
    step();
    bus.issue_en = 1'b0;
  endtask

  // Bounded wait for a head entry, check it, then pop it.
  task automatic expect_out(input string tag, input logic [15:0] exp);
    int t;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      step();
      t++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    check(tag, bus.out_vec, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals [4];
    int n;

    bus.issue_en      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.clr_overflow  = 1'b0;
    bus1.issue_en     = 1'b0;
    bus1.out_ready    = 1'b0;
    bus1.clr_overflow = 1'b0;
    beat_val          = '0;
    beat_val1         = '0;

    // T1: reset state
    repeat (3) step();
    check("t1_valid",   bus.out_valid,   0);
    check("t1_vec",     bus.out_vec,     0);
    check("t1_ready",   bus.issue_ready, 1);
    check("t1_ovf",     bus.overflow,    0);
    rst_n = 1'b1;
    step();

    // T2: basic group, one-cycle output pulse
    bus.out_ready = 1'b1;
    repeat (4) beat(16'h0110);
    check("t2_pre_valid", bus.out_valid, 0);
    step();
    check("t2_valid", bus.out_valid, 1);
    check("t2_vec",   bus.out_vec,   16'h0440);
    step();
    check("t2_pulse_end", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // T3: saturation then fresh group
    repeat (4) beat(16'h80F0);
    repeat (4) beat(16'h0101);
    expect_out("t3_sat",   16'hFFFF);
    expect_out("t3_fresh", 16'h0404);

    // T4: credit-obeying issuer under backpressure
    n = 0;
    while (bus.issue_ready && n < 40) begin
      beat(16'(((n / 4) + 1) * 16'h0101));
      n++;
    end
    check("t4_beats",     n,               13);
    check("t4_ready_low", bus.issue_ready, 0);
    check("t4_ovf",       bus.overflow,    0);
    expect_out("t4_g1", 16'h0404);
    expect_out("t4_g2", 16'h0808);
    expect_out("t4_g3", 16'h0C0C);
    repeat (3) beat(16'h0404);
    expect_out("t4_g4", 16'h1010);

    // T4: push and pop together while full
    for (int i = 0; i < 16; i++) beat(16'(((i / 4) + 1) * 16'h0101));
    repeat (4) beat(16'h0505);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_pp_head", bus.out_vec,  16'h0808);
    check("t4_pp_ovf",  bus.overflow, 0);
    expect_out("t4_pp_b", 16'h0808);
    expect_out("t4_pp_c", 16'h0C0C);
    expect_out("t4_pp_d", 16'h1010);
    expect_out("t4_pp_e", 16'h1414);
    check("t4_empty", bus.out_valid, 0);

    // T5: forced overflow, clear, and set-beats-clear
    for (int i = 0; i < 16; i++) beat(16'(((i / 4) + 1) * 16'h0101));
    step();
    repeat (4) beat(16'h0909);
    step();
    check("t5_ovf_set", bus.overflow, 1);
    check("t5_head",    bus.out_vec,  16'h0404);
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
    check("t5_ovf_clr", bus.overflow, 0);
    repeat (4) beat(16'h0909);
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
    check("t5_set_wins", bus.overflow, 1);
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
    check("t5_ovf_clr2", bus.overflow, 0);
    expect_out("t5_d1", 16'h0404);
    expect_out("t5_d2", 16'h0808);
    expect_out("t5_d3", 16'h0C0C);
    expect_out("t5_d4", 16'h1010);
    check("t5_empty", bus.out_valid, 0);
    repeat (4) beat(16'h0101);
    expect_out("t5_after", 16'h0404);

    // T1/T6: mid-cycle async reset discards FIFO, partial group and capture in flight
    repeat (4) beat(16'h0303);
    step();
    check("t6_pre_valid", bus.out_valid, 1);
    repeat (2) beat(16'h0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid,   0);
    check("t6_rst_vec",   bus.out_vec,     0);
    check("t6_rst_ready", bus.issue_ready, 1);
    #1;
    rst_n = 1'b1;
    step();
    repeat (4) beat(16'h0202);
    expect_out("t6_group", 16'h0808);

    // T6: ACC_LEN=1 passes each beat straight through
    vals[0] = 16'h1234;
    vals[1] = 16'hFFFF;
    vals[2] = 16'h0001;
    vals[3] = 16'h80F0;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat_val1     = vals[i];
      bus1.issue_en = 1'b1;
      step();
      if (i > 0) check($sformatf("t6_acc1_%0d", i - 1), bus1.out_vec, vals[i-1]);
    end
    bus1.issue_en = 1'b0;
    step();
    check("t6_acc1_3",     bus1.out_vec,   vals[3]);
    check("t6_acc1_valid", bus1.out_valid, 1);
    step();
    check("t6_acc1_empty", bus1.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
